display_in: RTL and testbench

Receiving end of the serial 7-segment link. Deserializes the 32-bit segment frame (clock, data, latch) produced by the display transmitter and decodes each segment byte back to BCD. Reports DP bits, dash/invalid codes and framing errors. Used as the loopback checker on the calculator board and as the behavioural model of the external shift-register/driver.

---
 rtl/display_pkg.sv | 75 +++++++
 rtl/display_in_sync_edge.sv | 30 +++
 rtl/display_in.sv | 129 ++++++++++++
 tb/tb_display_in.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the serial 7-segment link: segment codes, decode helpers
// and the receiver FSM state encoding. Segment byte layout is {a,b,c,d,e,f,g,dp}.
package display_pkg;

  localparam int FRAME_W = 32;
  localparam int DIGITS  = 4;

  localparam logic [7:0] SEG_0    = 8'hFC;
  localparam logic [7:0] SEG_1    = 8'h60;
  localparam logic [7:0] SEG_2    = 8'hDA;
  localparam logic [7:0] SEG_3    = 8'hF2;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'hB6;
  localparam logic [7:0] SEG_6    = 8'hBE;
  localparam logic [7:0] SEG_7    = 8'hE0;
  localparam logic [7:0] SEG_8    = 8'hFE;
  localparam logic [7:0] SEG_9    = 8'hF6;
  localparam logic [7:0] SEG_DASH = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       err;
    logic       dash;
    logic [3:0] nib;
  } dec_t;

  // Digits match with the DP bit ignored; the dash must match exactly.
  function automatic dec_t seg2bcd(input logic [7:0] seg);
    dec_t r;
    r.err  = 1'b0;
    r.dash = 1'b0;
    r.nib  = 4'hF;
    case ({seg[7:1], 1'b0})
      SEG_0:   r.nib = 4'd0;
      SEG_1:   r.nib = 4'd1;
      SEG_2:   r.nib = 4'd2;
      SEG_3:   r.nib = 4'd3;
      SEG_4:   r.nib = 4'd4;
      SEG_5:   r.nib = 4'd5;
      SEG_6:   r.nib = 4'd6;
      SEG_7:   r.nib = 4'd7;
      SEG_8:   r.nib = 4'd8;
      SEG_9:   r.nib = 4'd9;
      default: begin
        if (seg == SEG_DASH) r.dash = 1'b1;
        else                 r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd2seg(input logic [3:0] bcd);
    logic [7:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_in_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, followed by a registered
// rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/display_in.sv
// Serial 7-segment link receiver: shifts in the 32-bit segment frame, captures it
// on latch, decodes one byte per cycle and commits BCD/DP/dash/error results.
module display_in
  import display_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_clk,
  input  logic        ser_data,
  input  logic        ser_latch,
  output logic [15:0] bcd_out,
  output logic [3:0]  dp_out,
  output logic [3:0]  dash_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic [1:0]  fsm_state
);

  logic clk_rise, latch_rise, data_lvl;
  logic clk_lvl_unused, latch_lvl_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst(rst), .d(ser_clk), .level(clk_lvl_unused), .rise(clk_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst(rst), .d(ser_data), .level(data_lvl), .rise()
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .rst(rst), .d(ser_latch), .level(latch_lvl_unused), .rise(latch_rise)
  );

  state_t             state;
  logic [FRAME_W-1:0] sr, sr_next, frame;
  logic [CNT_W-1:0]   bit_cnt, cnt_next;
  logic               len_ok;
  logic [1:0]         d;
  logic [15:0]        bcd_sh, bcd_nx;
  logic [3:0]         dp_sh, dp_nx, dash_sh, dash_nx;
  logic               err_sh, err_nx;
  dec_t               cur;

  // A bit arriving in the same cycle as the latch belongs to the closing frame.
  always_comb begin
    sr_next  = sr;
    cnt_next = bit_cnt;
    if (clk_rise) begin
      sr_next  = {data_lvl, sr[FRAME_W-1:1]};
      cnt_next = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;
    end
  end

  always_comb begin
    cur     = seg2bcd(frame[8*int'(d) +: 8]);
    bcd_nx  = bcd_sh;
    dp_nx   = dp_sh;
    dash_nx = dash_sh;
    bcd_nx[4*int'(d) +: 4] = cur.nib;
    dp_nx[d]   = frame[8*int'(d)];
    dash_nx[d] = cur.dash;
    err_nx     = err_sh | cur.err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sr          <= '0;
      frame       <= '0;
      bit_cnt     <= '0;
      len_ok      <= 1'b0;
      d           <= 2'd0;
      bcd_sh      <= '0;
      dp_sh       <= '0;
      dash_sh     <= '0;
      err_sh      <= 1'b0;
      bcd_out     <= '0;
      dp_out      <= '0;
      dash_out    <= '0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      sr          <= sr_next;
      bit_cnt     <= cnt_next;
      case (state)
        ST_IDLE: begin
          if (latch_rise) begin
            frame   <= sr_next;
            len_ok  <= (cnt_next == CNT_W'(FRAME_W));
            bit_cnt <= '0;
            d       <= 2'd0;
            err_sh  <= 1'b0;
            state   <= ST_DEC;
          end
        end
        ST_DEC: begin
          overrun <= latch_rise;
          bcd_sh  <= bcd_nx;
          dp_sh   <= dp_nx;
          dash_sh <= dash_nx;
          err_sh  <= err_nx;
          d       <= d + 2'd1;
          // Last slot: commit so the outputs and the pulse are visible in DONE.
          if (d == 2'(DIGITS - 1)) begin
            bcd_out     <= bcd_nx;
            dp_out      <= dp_nx;
            dash_out    <= dash_nx;
            frame_err   <= ~len_ok | err_nx;
            frame_valid <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          overrun <= latch_rise;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_display_in.sv
// Directed bench for display_in: serial frames driven bit by bit, latch timing,
// decoded outputs checked against hand-computed values.
module tb_display_in;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser_clk = 1'b0;
  logic        ser_data = 1'b0;
  logic        ser_latch = 1'b0;
  logic [15:0] bcd_out;
  logic [3:0]  dp_out, dash_out;
  logic        frame_valid, frame_err, overrun;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int ov_cnt = 0;
  logic [15:0] exp_q[$];

  display_in #(.SYNC_STAGES(2), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data),
    .ser_latch(ser_latch), .bcd_out(bcd_out), .dp_out(dp_out),
    .dash_out(dash_out), .frame_valid(frame_valid), .frame_err(frame_err),
    .overrun(overrun), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (overrun)     ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send_bit(input logic b);
    ser_data = b;
    repeat (3) @(posedge clk);
    #1 ser_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 ser_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic latch_check(input string tag, input logic [15:0] eb, input logic [3:0] edp,
                             input logic [3:0] edash, input logic eerr);
    int lat, fv0, ov0;
    logic seen;
    logic [15:0] exp_bcd;
    exp_q.push_back(eb);
    fv0 = fv_cnt;
    ov0 = ov_cnt;
    ser_latch = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 4) ser_latch = 1'b0;
      if (frame_valid) seen = 1'b1;
    end
    ser_latch = 1'b0;
    exp_bcd = exp_q.pop_front();
    check({tag, "_valid"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
    check({tag, "_dp"}, 32'(dp_out), 32'(edp));
    check({tag, "_dash"}, 32'(dash_out), 32'(edash));
    check({tag, "_err"}, 32'(frame_err), 32'(eerr));
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_pulses"}, fv_cnt - fv0, 1);
    check({tag, "_no_overrun"}, ov_cnt - ov0, 0);
    check({tag, "_hold"}, 32'(bcd_out), 32'(exp_bcd));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bcd"}, 32'(bcd_out), 32'h0);
    check({tag, "_dp"}, 32'(dp_out), 32'h0);
    check({tag, "_dash"}, 32'(dash_out), 32'h0);
    check({tag, "_err"}, 32'(frame_err), 32'h0);
    check({tag, "_valid"}, 32'(frame_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_state"}, 32'(fsm_state), 32'h0);
  endtask

  initial begin : main
    int fv0, ov0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    // 1234, clean
    send_bits(32'h60DAF266, 32);
    latch_check("f1234", 16'h1234, 4'h0, 4'h0, 1'b0);

    // dash in slot 2
    send_bits(32'h6002F266, 32);
    latch_check("fdash", 16'h1F34, 4'h0, 4'b0100, 1'b0);

    // 0,5,6,4 with DP set on slot 0
    send_bits(32'hFCB6BE67, 32);
    latch_check("fdp", 16'h0564, 4'b0001, 4'h0, 1'b0);

    // slot 0 = 8'h01: not a digit, not a dash, DP set
    send_bits(32'hE0FEF601, 32);
    latch_check("fbad", 16'h789F, 4'b0001, 4'h0, 1'b1);

    // 31 bits: frame = {0x60DAF266[30:0], bit 31 of previous frame (1)} = 0xC1B5E4CD
    send_bits(32'h60DAF266, 31);
    latch_check("f31", 16'hFFFF, 4'b1101, 4'h0, 1'b1);

    // 33 bits: leading extra bit falls off, last 32 decode as 1234
    send_bit(1'b1);
    send_bits(32'h60DAF266, 32);
    latch_check("f33", 16'h1234, 4'h0, 4'h0, 1'b1);

    // second latch rise two cycles after the first
    send_bits(32'hFCB6BE67, 32);
    fv0 = fv_cnt;
    ov0 = ov_cnt;
    ser_latch = 1'b1;
    @(posedge clk); #1 ser_latch = 1'b0;
    @(posedge clk); #1 ser_latch = 1'b1;
    repeat (12) @(posedge clk);
    #1 ser_latch = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_valid", fv_cnt - fv0, 1);
    check("ovr_bcd", 32'(bcd_out), 32'h0564);
    check("ovr_dp", 32'(dp_out), 32'h1);
    check("ovr_err", 32'(frame_err), 32'h0);

    // reset while decoding
    send_bits(32'h60DAF266, 32);
    fv0 = fv_cnt;
    ser_latch = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    ser_latch = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("rst_dec");
    repeat (15) @(posedge clk);
    #1;
    check("rst_dec_no_valid", fv_cnt - fv0, 0);
    check("rst_dec_bcd_hold", 32'(bcd_out), 32'h0);

    // clean frame after reset: 9,8,7,6
    send_bits(32'hF6FEE0BE, 32);
    latch_check("f9876", 16'h9876, 4'h0, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
